// File: rtl/sent_tx_pulse_engine.sv
//------------------------------------------------------------------------------
// sent_tx_pulse_engine
//   SENT transmit pulse generator. Typed pulse commands (SYNC/DATA/PAUSE/CLEAR)
//   arrive over valid/ready into a one-entry holding register. The engine emits
//   tick-aligned pulses on data_pulse_o: LOW_TICKS ticks low, then high until
//   the pulse length L is reached. Commands queued during a pulse start on the
//   tick the previous pulse ends, so consecutive pulses have no gap.
//
//   Optional feature macro: SENT_TX_CONST_FRAME_EN
//     defined   : PAUSE stretches the frame to FRAME_TICKS (never below
//                 MIN_PAUSE); frame_ovf_o flags pauses that had to be clipped.
//     undefined : PAUSE is a fixed PAUSE_TICKS, frame_ovf_o is tied low.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module sent_tx_pulse_engine #(
   parameter int CNT_W       = 10,
   parameter int LOW_TICKS   = 5,
   parameter int SYNC_TICKS  = 56,
   parameter int NIB_OFFSET  = 12,
   parameter int PAUSE_TICKS = 20,
   parameter int FRAME_TICKS = 282,
   parameter int MIN_PAUSE   = 12
) (
   input  logic       clk_tx,
   input  logic       reset_tx,
   input  logic       ticks_i,
   input  logic       cmd_valid_i,
   input  logic [1:0] cmd_type_i,
   input  logic [3:0] cmd_nibble_i,
   output logic       cmd_ready_o,
   output logic       pulse_done_o,
   output logic       busy_o,
   output logic       frame_ovf_o,
   output logic       data_pulse_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam logic [1:0] CMD_SYNC  = 2'd0;
   localparam logic [1:0] CMD_DATA  = 2'd1;
   localparam logic [1:0] CMD_PAUSE = 2'd2;
   localparam logic [1:0] CMD_CLEAR = 2'd3;

   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LP_LOW     = CNT_W'(LOW_TICKS);
   localparam logic [CNT_W-1:0] LP_MIN_LEN = CNT_W'(LOW_TICKS + 1);
   localparam logic [CNT_W-1:0] LP_SYNC    = CNT_W'(SYNC_TICKS);
   localparam logic [CNT_W-1:0] LP_NIB_OFF = CNT_W'(NIB_OFFSET);

   // state and registers
   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_tick_q;
   logic [CNT_W-1:0]   r_tick_cnt;
   logic [CNT_W-1:0]   r_len;
   logic [1:0]         r_type;
   logic [CNT_W-1:0]   r_frame_acc;
   logic               r_out;
   logic               r_done;
   logic               r_pend_vld;
   logic [1:0]         r_pend_type;
   logic [3:0]         r_pend_nib;

   // combinational helpers
   logic               w_tick_rise;
   logic               w_accept;
   logic               w_pend_clear;
   logic               w_pend_pulse;
   logic               w_pulse_end;
   logic               w_start;
   logic [CNT_W:0]     w_sat_sum;
   logic [CNT_W-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   w_pause_len;
   logic [CNT_W-1:0]   w_raw_len;
   logic [CNT_W-1:0]   w_start_len;

   assign w_tick_rise  = ticks_i & ~r_tick_q;
   assign cmd_ready_o  = ~r_pend_vld & ~reset_tx;
   assign w_accept     = cmd_valid_i & cmd_ready_o;
   assign w_pend_clear = r_pend_vld & (r_pend_type == CMD_CLEAR);
   assign w_pend_pulse = r_pend_vld & (r_pend_type != CMD_CLEAR);
   assign w_pulse_end  = (r_state == ST_HIGH) & w_tick_rise & (r_tick_cnt == r_len);

   assign data_pulse_o = r_out;
   assign pulse_done_o = r_done;
   assign busy_o       = (r_state != ST_IDLE) | r_pend_vld;

   // Frame accumulator next value: pulses add their length (saturating), a
   // finished PAUSE restarts the frame, and a CLEAR overrides everything.
   assign w_sat_sum = {1'b0, r_frame_acc} + {1'b0, r_len};

   always_comb begin
      w_acc_nxt = r_frame_acc;
      if (w_pulse_end) begin
         if (r_type == CMD_PAUSE) begin
            w_acc_nxt = '0;
         end else if (w_sat_sum[CNT_W]) begin
            w_acc_nxt = '1;
         end else begin
            w_acc_nxt = w_sat_sum[CNT_W-1:0];
         end
      end
      if (w_pend_clear) begin
         w_acc_nxt = '0;
      end
   end

`ifdef SENT_TX_CONST_FRAME_EN
   localparam logic [CNT_W-1:0] LP_FRAME     = CNT_W'(FRAME_TICKS);
   localparam logic [CNT_W-1:0] LP_MIN_PAUSE = CNT_W'(MIN_PAUSE);

   logic [CNT_W:0]     w_pause_need;
   logic               w_pause_short;
   logic               r_ovf;

   // The pause fills whatever is left of the frame, measured with the length
   // of a pulse ending in this same cycle already included.
   assign w_pause_need  = {1'b0, w_acc_nxt} + {1'b0, LP_MIN_PAUSE};
   assign w_pause_short = w_pause_need > {1'b0, LP_FRAME};
   assign w_pause_len   = w_pause_short ? LP_MIN_PAUSE : (LP_FRAME - w_acc_nxt);

   // Overflow strobe coincides with the start of a clipped pause.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= w_start & (r_pend_type == CMD_PAUSE) & w_pause_short;
      end
   end

   assign frame_ovf_o = r_ovf;
`else
   localparam logic [CNT_W-1:0] LP_PAUSE = CNT_W'(PAUSE_TICKS);

   assign w_pause_len = LP_PAUSE;
   assign frame_ovf_o = 1'b0;
`endif

   // Length of the pending command, clamped so the high phase always exists.
   always_comb begin
      w_raw_len = LP_SYNC;
      case (r_pend_type)
         CMD_DATA:  w_raw_len = LP_NIB_OFF + {{(CNT_W-4){1'b0}}, r_pend_nib};
         CMD_PAUSE: w_raw_len = w_pause_len;
         default:   w_raw_len = LP_SYNC;
      endcase
      w_start_len = (w_raw_len <= LP_LOW) ? LP_MIN_LEN : w_raw_len;
   end

   // Next-state logic: pulses start on a tick edge, either from idle or
   // directly at the end of the previous pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_tick_rise & w_pend_pulse) begin
               w_start     = 1'b1;
               w_state_nxt = ST_LOW;
            end
         end
         ST_LOW: begin
            if (w_tick_rise && (r_tick_cnt == LP_LOW)) begin
               w_state_nxt = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (w_pulse_end) begin
               if (w_pend_pulse) begin
                  w_start     = 1'b1;
                  w_state_nxt = ST_LOW;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // One-entry holding register; emptied when a pulse starts or a CLEAR is consumed.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         r_pend_vld  <= 1'b0;
         r_pend_type <= CMD_SYNC;
         r_pend_nib  <= 4'd0;
      end else if (w_accept) begin
         r_pend_vld  <= 1'b1;
         r_pend_type <= cmd_type_i;
         r_pend_nib  <= cmd_nibble_i;
      end else if (w_start | w_pend_clear) begin
         r_pend_vld  <= 1'b0;
      end
   end

   // Tick edge detector, tick counter, active pulse parameters and the line.
   always_ff @(posedge clk_tx or posedge reset_tx) begin
      if (reset_tx) begin
         r_tick_q    <= 1'b0;
         r_tick_cnt  <= '0;
         r_len       <= '0;
         r_type      <= CMD_SYNC;
         r_frame_acc <= '0;
         r_out       <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_tick_q    <= ticks_i;
         r_frame_acc <= w_acc_nxt;
         r_done      <= w_pulse_end;
         if (w_start) begin
            r_tick_cnt <= LP_ONE;
            r_len      <= w_start_len;
            r_type     <= r_pend_type;
            r_out      <= 1'b0;
         end else if (w_tick_rise && (r_state != ST_IDLE)) begin
            r_tick_cnt <= r_tick_cnt + LP_ONE;
            if ((r_state == ST_LOW) && (r_tick_cnt == LP_LOW)) begin
               r_out <= 1'b1;
            end
            if (w_pulse_end) begin
               r_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sent_tx_pulse_engine.sv
//------------------------------------------------------------------------------
// tb_sent_tx_pulse_engine
//   Table of pulse commands with expected lengths, a scoreboard of expected
//   pulses, and a line monitor that measures every pulse in ticks. Hand-written
//   sequences cover CLEAR, reset mid-pulse and the constant-frame pause.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sent_tx_pulse_engine;

   localparam logic [1:0] T_SYNC  = 2'd0;
   localparam logic [1:0] T_DATA  = 2'd1;
   localparam logic [1:0] T_PAUSE = 2'd2;
   localparam logic [1:0] T_CLEAR = 2'd3;

`ifdef SENT_TX_CONST_FRAME_EN
   localparam int TBL_PAUSE_LEN = 170;   // 282 - (56+27+12+17)
   localparam int CLR_PAUSE_LEN = 226;   // 282 - 56, acc cleared mid-SYNC
   localparam int EXP_OVF       = 1;
   localparam int EXP_DONE      = 28;
`else
   localparam int TBL_PAUSE_LEN = 20;
   localparam int CLR_PAUSE_LEN = 20;
   localparam int EXP_OVF       = 0;
   localparam int EXP_DONE      = 8;
`endif

   logic       clk_tx       = 1'b0;
   logic       reset_tx     = 1'b1;
   logic       ticks_i      = 1'b0;
   logic       cmd_valid_i  = 1'b0;
   logic [1:0] cmd_type_i   = 2'd0;
   logic [3:0] cmd_nibble_i = 4'd0;
   logic       cmd_ready_o;
   logic       pulse_done_o;
   logic       busy_o;
   logic       frame_ovf_o;
   logic       data_pulse_o;

   sent_tx_pulse_engine dut (
      .clk_tx       (clk_tx),
      .reset_tx     (reset_tx),
      .ticks_i      (ticks_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_type_i   (cmd_type_i),
      .cmd_nibble_i (cmd_nibble_i),
      .cmd_ready_o  (cmd_ready_o),
      .pulse_done_o (pulse_done_o),
      .busy_o       (busy_o),
      .frame_ovf_o  (frame_ovf_o),
      .data_pulse_o (data_pulse_o)
   );

   always #5 clk_tx = ~clk_tx;

   // tick strobe: rising edge every 4 clocks
   always begin
      repeat (2) @(negedge clk_tx);
      ticks_i = ~ticks_i;
   end

   // bench tick counter, advancing on the same edges the DUT treats as ticks
   logic tb_tick_q = 1'b0;
   int   tick_no   = 0;
   always @(posedge clk_tx) begin
      tb_tick_q <= ticks_i;
      if (ticks_i && !tb_tick_q) tick_no <= tick_no + 1;
   end

   typedef struct {
      int    len;
      bit    b2b;
      string name;
   } exp_t;

   typedef struct {
      logic [1:0] t;
      logic [3:0] nib;
      int         len;
      bit         b2b;
      string      name;
   } vec_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   int   ovf_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // line monitor: measures low phase, total length and gap of each pulse
   logic prev_out      = 1'b1;
   bit   fell_now;
   int   fall_tick     = 0;
   int   last_end_tick = -1000;
   exp_t mon_e;

   always @(negedge clk_tx) begin
      if (reset_tx) begin
         prev_out = 1'b1;
      end else begin
         fell_now = prev_out && !data_pulse_o;
         if (pulse_done_o) begin
            done_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_strobe actual=unexpected required=none at tick %0d", tick_no);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_len"}, tick_no - fall_tick, mon_e.len);
            end
            last_end_tick = tick_no;
         end
         if (!prev_out && data_pulse_o) begin
            check("low_phase_ticks", tick_no - fall_tick, 5);
         end
         if (fell_now) begin
            fall_tick = tick_no;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL line_fall actual=unexpected required=none at tick %0d", tick_no);
            end else if (sb[0].b2b) begin
               check({sb[0].name, "_gap"}, tick_no - last_end_tick, 0);
            end
         end
         if (frame_ovf_o) begin
            ovf_cnt++;
            check("ovf_at_pause_start", fell_now, 1);
         end
         prev_out = data_pulse_o;
      end
   end

   task automatic send(input logic [1:0] t, input logic [3:0] n, input int len,
                       input bit b2b, input string name);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk_tx);
      cmd_valid_i  = 1'b1;
      cmd_type_i   = t;
      cmd_nibble_i = n;
      while (cmd_ready_o !== 1'b1 && guard < 4000) begin
         @(negedge clk_tx);
         guard++;
      end
      if (guard >= 4000) begin
         checks++;
         errors++;
         $display("FAIL %s_accept actual=ready_low required=ready_high", name);
         cmd_valid_i = 1'b0;
         return;
      end
      if (t != T_CLEAR) begin
         e.len  = len;
         e.b2b  = b2b;
         e.name = name;
         sb.push_back(e);
      end
      @(negedge clk_tx);
      check({name, "_ready_after_accept"}, cmd_ready_o, 0);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      while ((busy_o !== 1'b0 || sb.size() != 0) && guard < 20000) begin
         @(negedge clk_tx);
         guard++;
      end
      check({name, "_busy_end"}, busy_o, 0);
      check({name, "_pulses_left"}, sb.size(), 0);
   endtask

   initial begin
      #400us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   done_before;

      tbl[0] = '{T_SYNC,  4'h0, 56,            1'b0, "tbl_sync"};
      tbl[1] = '{T_DATA,  4'hF, 27,            1'b1, "tbl_data_f"};
      tbl[2] = '{T_DATA,  4'h0, 12,            1'b1, "tbl_data_0"};
      tbl[3] = '{T_DATA,  4'h5, 17,            1'b1, "tbl_data_5"};
      tbl[4] = '{T_PAUSE, 4'h0, TBL_PAUSE_LEN, 1'b1, "tbl_pause"};
      tbl[5] = '{T_DATA,  4'hA, 22,            1'b1, "tbl_data_a"};

      // reset state
      repeat (3) @(negedge clk_tx);
      check("rst_line_high", data_pulse_o, 1);
      check("rst_done_low",  pulse_done_o, 0);
      check("rst_ovf_low",   frame_ovf_o,  0);
      check("rst_busy_low",  busy_o,       0);
      check("rst_ready_in_reset", cmd_ready_o, 0);
      reset_tx = 1'b0;
      @(negedge clk_tx);
      check("rst_ready_after", cmd_ready_o, 1);
      repeat (8) @(negedge clk_tx);

      // table-driven back-to-back pulse train
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].t, tbl[i].nib, tbl[i].len, tbl[i].b2b, tbl[i].name);
      end
      wait_idle("table");

      // CLEAR in the middle of a SYNC: no pulse, ready back on the next cycle
      send(T_SYNC, 4'h0, 56, 1'b0, "clr_sync");
      repeat (40) @(negedge clk_tx);
      cmd_valid_i = 1'b1;
      cmd_type_i  = T_CLEAR;
      check("clear_ready_before", cmd_ready_o, 1);
      @(negedge clk_tx);
      check("clear_ready_taken", cmd_ready_o, 0);
      cmd_valid_i = 1'b0;
      @(negedge clk_tx);
      check("clear_ready_back", cmd_ready_o, 1);
      check("clear_line_high", data_pulse_o, 1);
      check("clear_busy", busy_o, 1);
      send(T_PAUSE, 4'h0, CLR_PAUSE_LEN, 1'b1, "clr_pause");
      wait_idle("clear");

      // reset during the low phase of a DATA pulse with another pending
      send(T_DATA, 4'h3, 15, 1'b0, "rst_data3");
      send(T_DATA, 4'h4, 16, 1'b1, "rst_data4");
      @(negedge clk_tx);
      check("abort_in_low", data_pulse_o, 0);
      check("abort_pending_busy", busy_o, 1);
      done_before = done_cnt;
      #2;
      reset_tx = 1'b1;
      #1;
      check("abort_line_async", data_pulse_o, 1);
      check("abort_done_low", pulse_done_o, 0);
      check("abort_busy_cleared", busy_o, 0);
      sb.delete();
      repeat (3) @(negedge clk_tx);
      reset_tx = 1'b0;
      #1;
      check("abort_ready_release", cmd_ready_o, 1);
      @(negedge clk_tx);
      check("abort_ready_first_cycle", cmd_ready_o, 1);
      check("abort_not_busy", busy_o, 0);
      repeat (120) @(negedge clk_tx);
      check("abort_no_done", done_cnt, done_before);
      check("abort_line_idle", data_pulse_o, 1);

`ifdef SENT_TX_CONST_FRAME_EN
      // SYNC + 6x DATA 0 = 128 ticks, pause fills the frame to 282
      send(T_SYNC, 4'h0, 56, 1'b0, "cf_sync");
      for (int i = 0; i < 6; i++) send(T_DATA, 4'h0, 12, 1'b1, "cf_data0");
      send(T_PAUSE, 4'h0, 154, 1'b1, "cf_pause");
      wait_idle("const_frame");

      // SYNC + 10x DATA F = 326 ticks, pause clipped to the minimum
      send(T_SYNC, 4'h0, 56, 1'b0, "ovf_sync");
      for (int i = 0; i < 10; i++) send(T_DATA, 4'hF, 27, 1'b1, "ovf_dataf");
      send(T_PAUSE, 4'h0, 12, 1'b1, "ovf_pause");
      wait_idle("overflow");
`endif

      check("ovf_count", ovf_cnt, EXP_OVF);
      check("done_count", done_cnt, EXP_DONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
